// File: rtl/rr_arb2_mux_sel_pkg.sv
// Shared definitions for the two-channel round-robin arbiter / output register.
// Holds the FSM encoding and the channel identifiers used for the mux select.
package rr_arb2_mux_sel_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/rr_arb2_mux_sel_mux2x1_bus.sv
// WIDTH-bit 2:1 mux; sel picks channel 0 (a) or channel 1 (b).
module mux2x1_bus
  import rr_arb2_mux_sel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (sel == CH0) ? a : b;

endmodule

// File: rtl/rr_arb2_mux_sel.sv
// Two-channel round-robin arbiter feeding a one-entry registered output stage,
// with saturating per-channel grant counters.
module rr_arb2_mux_sel
  import rr_arb2_mux_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  // Handshakes: a word moves on a port in any cycle where its valid and ready
  // are both high at posedge clk. Readies never depend on the same port's ready
  // downstream beyond out_ready, and are forced low while rst_n is low.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  logic             can_load;
  logic             any_valid;
  logic             gnt_ch;
  logic             do_load;
  logic [WIDTH-1:0] mux_data;

  assign any_valid = in0_valid | in1_valid;
  assign can_load  = rst_n & ((state_q == ST_EMPTY) | out_ready);

  // Contest goes to the channel that did not win last; a lone requester just wins.
  assign gnt_ch  = (in0_valid & in1_valid) ? ~last_q : in1_valid;
  assign do_load = can_load & any_valid;

  assign in0_ready = do_load & (gnt_ch == CH0);
  assign in1_ready = do_load & (gnt_ch == CH1);

  mux2x1_bus #(.WIDTH(WIDTH)) u_mux (
    .sel (gnt_ch),
    .a   (in0_data),
    .b   (in1_data),
    .y   (mux_data)
  );

  always_comb begin
    state_d = state_q;
    if (do_load) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= CH1;
      data_q  <= '0;
      sel_q   <= CH0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (do_load) begin
        data_q <= mux_data;
        sel_q  <= gnt_ch;
        last_q <= gnt_ch;
      end
      // Clear takes priority over a same-cycle grant.
      if (clr_cnt) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
      end else if (do_load) begin
        if ((gnt_ch == CH0) && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + 1'b1;
        if ((gnt_ch == CH1) && (cnt1_q != CNT_MAX)) cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign sel       = sel_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_rr_arb2_mux_sel.sv
// Directed bench for rr_arb2_mux_sel: an 8-bit-counter instance plus a 2-bit-counter
// instance sharing the same stimulus, so saturation is visible alongside the main run.
module tb_rr_arb2_mux_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in0_data, in1_data;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, sel, clr_cnt;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  logic       s_in0_ready, s_in1_ready;
  logic [7:0] s_out_data;
  logic       s_out_valid, s_sel;
  logic [1:0] s_gnt_cnt0, s_gnt_cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_arb2_mux_sel #(.WIDTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .clr_cnt(clr_cnt), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  rr_arb2_mux_sel #(.WIDTH(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(s_in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(s_in1_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .sel(s_sel), .clr_cnt(clr_cnt), .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic r0, input logic r1);
    chk({tag, "_in0_ready"}, {31'd0, in0_ready}, {31'd0, r0});
    chk({tag, "_in1_ready"}, {31'd0, in1_ready}, {31'd0, r1});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_out_data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, "_sel"}, {31'd0, sel}, {31'd0, s});
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [1:0] sc0, input logic [1:0] sc1);
    chk({tag, "_cnt0"}, {24'd0, gnt_cnt0}, {24'd0, c0});
    chk({tag, "_cnt1"}, {24'd0, gnt_cnt1}, {24'd0, c1});
    chk({tag, "_sat_cnt0"}, {30'd0, s_gnt_cnt0}, {30'd0, sc0});
    chk({tag, "_sat_cnt1"}, {30'd0, s_gnt_cnt1}, {30'd0, sc1});
  endtask

  initial begin
    // 1. Reset with both channels requesting.
    rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1; clr_cnt = 1'b0;
    in0_data = 8'h11; in1_data = 8'h22;
    #1;
    chk_ready("rst_comb", 1'b0, 1'b0);
    tick();
    tick();
    chk_ready("rst", 1'b0, 1'b0);
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    chk_cnt("rst", 8'd0, 8'd0, 2'd0, 2'd0);

    // 2. Both valid, free-flowing: ch0 wins first, then strict alternation.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in0_data = 8'hA0 + 8'(i / 2);
      in1_data = 8'hB0 + 8'(i / 2);
      #1;
      chk_ready("alt", (i % 2) == 0, (i % 2) == 1);
      tick();
      chk_out("alt", 1'b1, (i % 2 == 0) ? 8'hA0 + 8'(i / 2) : 8'hB0 + 8'(i / 2), (i % 2) == 1);
    end
    chk_cnt("alt", 8'd3, 8'd3, 2'd3, 2'd3);

    // 3. Back-pressure: held word and select stay put, no input accepted.
    out_ready = 1'b0; in0_data = 8'h55; in1_data = 8'h66;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ready("stall", 1'b0, 1'b0);
      tick();
      chk_out("stall", 1'b1, 8'hB2, 1'b1);
    end
    chk_cnt("stall", 8'd3, 8'd3, 2'd3, 2'd3);

    // 4. Lone ch1 wins three times; the following contest still goes to ch0.
    out_ready = 1'b1; in0_valid = 1'b0; in1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1_data = 8'hC0 + 8'(i);
      #1;
      chk_ready("lone1", 1'b0, 1'b1);
      tick();
      chk_out("lone1", 1'b1, 8'hC0 + 8'(i), 1'b1);
      chk({"lone1_cnt1"}, {24'd0, gnt_cnt1}, 32'd4 + 32'(i));
    end
    in0_valid = 1'b1; in0_data = 8'hD0; in1_data = 8'hD1;
    #1;
    chk_ready("contest", 1'b1, 1'b0);
    tick();
    chk_out("contest", 1'b1, 8'hD0, 1'b0);
    chk_cnt("contest", 8'd4, 8'd6, 2'd3, 2'd3);

    // Drain with clear: no input valid empties the stage, data/sel are kept.
    in0_valid = 1'b0; in1_valid = 1'b0; clr_cnt = 1'b1; in0_data = 8'h77;
    #1;
    chk_ready("drain", 1'b0, 1'b0);
    tick();
    chk_out("drain", 1'b0, 8'hD0, 1'b0);
    chk_cnt("drain", 8'd0, 8'd0, 2'd0, 2'd0);

    // 5. Ch0-only grants: 2-bit counter saturates at 3, 8-bit keeps counting.
    clr_cnt = 1'b0; in0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in0_data = 8'hE0 + 8'(i);
      #1;
      chk_ready("ch0", 1'b1, 1'b0);
      tick();
      chk_out("ch0", 1'b1, 8'hE0 + 8'(i), 1'b0);
      chk_cnt("ch0", 8'(i + 1), 8'd0, (i >= 2) ? 2'd3 : 2'(i + 1), 2'd0);
    end
    clr_cnt = 1'b1; in0_data = 8'hF0;
    #1;
    chk_ready("clr_gnt", 1'b1, 1'b0);
    tick();
    chk_out("clr_gnt", 1'b1, 8'hF0, 1'b0);
    chk_cnt("clr_gnt", 8'd0, 8'd0, 2'd0, 2'd0);

    // 6. Reset while full and stalled: word dropped, no ready even with out_ready high.
    clr_cnt = 1'b0; in1_valid = 1'b1; out_ready = 1'b0; in0_data = 8'h12; in1_data = 8'h34;
    tick();
    chk_out("full_stall", 1'b1, 8'hF0, 1'b0);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    chk_ready("rst_full", 1'b0, 1'b0);
    tick();
    chk_out("rst_full", 1'b0, 8'h00, 1'b0);
    chk_cnt("rst_full", 8'd0, 8'd0, 2'd0, 2'd0);
    rst_n = 1'b1;
    #1;
    chk_ready("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 8'h12, 1'b0);
    chk_cnt("post_rst", 8'd1, 8'd0, 2'd1, 2'd0);

    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
